// File: rtl/uart_word_transmitter_if.sv
// Word-transmit handshake bundle: requester drives word/start, transmitter returns busy/done and the serial line.
interface uart_word_transmitter_if;
  logic [31:0] TxD_word_data;
  logic        TxD_word_start;
  logic        TxD_busy;
  logic        TxD_word_done;
  logic        TxD;

  modport master (
    output TxD_word_data,
    output TxD_word_start,
    input  TxD_busy,
    input  TxD_word_done,
    input  TxD
  );

  modport slave (
    input  TxD_word_data,
    input  TxD_word_start,
    output TxD_busy,
    output TxD_word_done,
    output TxD
  );
endinterface

// File: rtl/uart_word_transmitter.sv
// Sends a 32-bit word as four back-to-back 8N1 frames, byte [7:0] first; the word takes 40 bit-times.
// Starts are accepted only while idle (busy low); requests made while busy are dropped, not queued.
module uart_word_transmitter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_word_transmitter_if.slave  tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      shift_q;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end_d;

  assign bit_end_d = (baud_cnt_q == CNT_LAST);

  // The word shifts out LSB first continuously, so byte k's bits are already at
  // shift_q[0] when its frame starts; no byte-select mux is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (tx.TxD_word_start) begin
          shift_q    <= tx.TxD_word_data;
          byte_idx_q <= '0;
          bit_idx_q  <= '0;
          baud_cnt_q <= '0;
          txd_q      <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= START;
        end
      end else begin
        baud_cnt_q <= bit_end_d ? '0 : baud_cnt_q + 1'b1;
        if (bit_end_d) begin
          case (state_q)
            START: begin
              txd_q     <= shift_q[0];
              shift_q   <= {1'b0, shift_q[31:1]};
              bit_idx_q <= '0;
              state_q   <= DATA;
            end
            DATA: begin
              if (bit_idx_q == 3'd7) begin
                txd_q   <= 1'b1;
                state_q <= STOP;
              end else begin
                txd_q     <= shift_q[0];
                shift_q   <= {1'b0, shift_q[31:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
            STOP: begin
              if (byte_idx_q == BYTE_LAST) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                byte_idx_q <= byte_idx_q + 2'd1;
                txd_q      <= 1'b0;
                state_q    <= START;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign tx.TxD           = txd_q;
  assign tx.TxD_busy      = busy_q;
  assign tx.TxD_word_done = done_q;

endmodule
